// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// FSM state type and a mode classification helper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } usr_state_e;

  // Only shift/rotate modes are worth repeating in a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m >= MODE_SHR) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value function for the universal shift register.
// Shared by single enabled operations and burst operations.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [2:0]   mode_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  input  logic         si_r_i,
  input  logic         si_l_i,
  output logic [N-1:0] q_o
);

  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_LOAD: q_o = d_i;
      MODE_SHR:  q_o = {si_r_i, q_i[N-1:1]};
      MODE_SHL:  q_o = {q_i[N-2:0], si_l_i};
      MODE_ROR:  q_o = {q_i[0], q_i[N-1:1]};
      MODE_ROL:  q_o = {q_i[N-2:0], q_i[N-1]};
      MODE_ASR:  q_o = {q_i[N-1], q_i[N-1:1]};
      default:   q_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register with single-cycle operations and a counted
// burst engine reporting busy/done.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d,
  input  logic          si_r,
  input  logic          si_l,
  input  logic          start,
  input  logic [CW-1:0] nshift,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done
);

  usr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_lat_q, mode_lat_d;
  logic [N-1:0]  val_q, val_d;
  logic          done_q, done_d;

  logic [2:0]    op_mode;
  logic [N-1:0]  op_result;

  // In BUSY the latched mode drives the datapath; live inputs are ignored.
  assign op_mode = (state_q == ST_BUSY) ? mode_lat_q : mode;

  usr_shift_unit #(
    .N(N)
  ) u_shift_unit (
    .mode_i (op_mode),
    .q_i    (val_q),
    .d_i    (d),
    .si_r_i (si_r),
    .si_l_i (si_l),
    .q_o    (op_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_lat_q <= MODE_HOLD;
      val_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_lat_q <= mode_lat_d;
      val_q      <= val_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_lat_d = mode_lat_q;
    val_d      = val_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_burst_mode(mode) && (nshift != '0)) begin
            state_d    = ST_BUSY;
            cnt_d      = nshift;
            mode_lat_d = mode;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          val_d = op_result;
        end
      end
      ST_BUSY: begin
        val_d = op_result;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    q    = val_q;
    so_r = val_q[0];
    so_l = val_q[N-1];
    busy = (state_q == ST_BUSY);
    done = done_q;
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at N=8.
module tb_universal_shift_reg;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk;
  logic          reset_n;
  logic          en;
  logic [2:0]    mode;
  logic [N-1:0]  d;
  logic          si_r;
  logic          si_l;
  logic          start;
  logic [CW-1:0] nshift;
  logic [N-1:0]  q;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  int n_checks;
  int n_errors;

  universal_shift_reg #(
    .N(N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .si_r    (si_r),
    .si_l    (si_l),
    .start   (start),
    .nshift  (nshift),
    .q       (q),
    .so_r    (so_r),
    .so_l    (so_l),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; start = 1'b0; mode = 3'b000; nshift = '0;
  endtask

  task automatic do_load(input logic [N-1:0] val);
    en = 1'b1; start = 1'b0; mode = 3'b001; d = val;
    tick();
    idle_inputs();
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    d = '0; si_r = 1'b0; si_l = 1'b0;
    idle_inputs();
    #3;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #9 reset_n = 1'b1;
    tick();
    check("idle_q", q, 8'h00);

    // Load then single SHR with si_r=1
    do_load(8'hB4);
    check("load_q", q, 8'hB4);
    check("load_so_l", so_l, 1);
    en = 1'b1; mode = 3'b010; si_r = 1'b1;
    tick();
    idle_inputs(); si_r = 1'b0;
    check("shr_q", q, 8'hDA);
    check("shr_so_r", so_r, 0);

    // ROL burst of 3, with disturbing inputs while busy
    do_load(8'h81);
    start = 1'b1; mode = 3'b101; nshift = 4'd3;
    tick();
    check("rol_e0_busy", busy, 1);
    check("rol_e0_q", q, 8'h81);
    check("rol_e0_done", done, 0);
    start = 1'b1; en = 1'b1; mode = 3'b001; d = 8'hFF; nshift = 4'd1;
    tick();
    check("rol_e1_q", q, 8'h03);
    check("rol_e1_busy", busy, 1);
    tick();
    check("rol_e2_q", q, 8'h06);
    check("rol_e2_done", done, 0);
    tick();
    check("rol_e3_q", q, 8'h0C);
    check("rol_e3_busy", busy, 0);
    check("rol_e3_done", done, 1);
    idle_inputs();
    tick();
    check("rol_e4_done", done, 0);
    check("rol_e4_q", q, 8'h0C);

    // ASR burst of 2
    do_load(8'h90);
    start = 1'b1; mode = 3'b110; nshift = 4'd2;
    tick();
    idle_inputs();
    tick();
    check("asr_e1_q", q, 8'hC8);
    tick();
    check("asr_q", q, 8'hE4);
    check("asr_done", done, 1);

    // SHL burst of 8 with si_l=0, bounded wait for done
    do_load(8'hFF);
    si_l = 1'b0;
    start = 1'b1; mode = 3'b011; nshift = 4'd8;
    tick();
    idle_inputs();
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("shl_cycles", waited, 8);
    check("shl_q", q, 8'h00);

    // Degenerate starts
    do_load(8'h5A);
    start = 1'b1; mode = 3'b010; nshift = 4'd0;
    tick();
    idle_inputs();
    check("deg0_done", done, 1);
    check("deg0_busy", busy, 0);
    check("deg0_q", q, 8'h5A);
    tick();
    check("deg0_done_clr", done, 0);
    start = 1'b1; mode = 3'b001; d = 8'hFF; nshift = 4'd5;
    tick();
    idle_inputs();
    check("degld_done", done, 1);
    check("degld_busy", busy, 0);
    check("degld_q", q, 8'h5A);
    tick();
    check("degld_done_clr", done, 0);
    check("degld_busy2", busy, 0);

    // start+en together: burst wins; then chain a second burst on done
    start = 1'b1; en = 1'b1; mode = 3'b100; nshift = 4'd1;
    tick();
    idle_inputs();
    check("arb_busy", busy, 1);
    check("arb_q", q, 8'h5A);
    tick();
    check("arb_q1", q, 8'h2D);
    check("arb_done", done, 1);
    start = 1'b1; mode = 3'b100; nshift = 4'd2;
    tick();
    idle_inputs();
    check("chain_busy", busy, 1);
    check("chain_done", done, 0);
    tick();
    check("chain_q1", q, 8'h96);
    tick();
    check("chain_q2", q, 8'h4B);
    check("chain_done2", done, 1);

    // Reset mid-burst
    do_load(8'hFF);
    si_r = 1'b0;
    start = 1'b1; mode = 3'b010; nshift = 4'd6;
    tick();
    idle_inputs();
    tick();
    tick();
    check("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_done", done, 0);
    do_load(8'hC3);
    start = 1'b1; mode = 3'b101; nshift = 4'd1;
    tick();
    idle_inputs();
    check("post_rst_busy", busy, 1);
    tick();
    check("post_rst_q", q, 8'h87);
    check("post_rst_done2", done, 1);

    // nshift > N: ROL by 9 equals ROL by 1
    start = 1'b1; mode = 3'b101; nshift = 4'd9;
    tick();
    idle_inputs();
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("rol9_cycles", waited, 9);
    check("rol9_q", q, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
